rca_seq_ctrl: RTL and testbench
===============================

# rca_seq_ctrl

Sequencing controller that performs WIDTH-bit addition by reusing one 4-bit ripple-carry slice (`rcadder_4`) over multiple cycles, one nibble per cycle, least significant first.
- The block latches the operands on a start handshake and steps a nibble index.
- It registers the inter-nibble carry and assembles the result in a shift-free indexed register.
- It signals completion with a one-cycle `done` pulse.
- It sits between a requesting datapath (ALU sequencer or accumulator) and the shared adder slice, trading latency for area.

## Interface
- `WIDTH`, default 16: operand width in bits. Must be a multiple of 4 and at least 4.
- `NIBBLES`, derived as WIDTH/4: number of RUN cycles. Not overridable.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request. Sampled only in IDLE.
- `a`  in  WIDTH  operand A. Latched when start is accepted.
- `b`  in  WIDTH  operand B. Latched when start is accepted.
- `cin`  in  1  carry-in. Latched when start is accepted.
- `sub`  in  1  subtract request. Present only with SUB_EN.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse. While it is high, the results are final.
- `sum`  out  WIDTH  result register.
- `cout`  out  1  carry out of the MSB nibble.
- `ovf`  out  1  two's-complement overflow.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - `start`=1 latches `a`, `b`, `cin` into `a_q`, `b_q`, `c_q`.
  - Sets `idx`=0 and moves to RUN.
  - `start`=0 stays in IDLE.
- RUN, each cycle:
  - The slice receives `a_q[4*idx+:4]`, `b_q[4*idx+:4]` and `c_q`.
  - The slice result is written to `sum[4*idx+:4]`; `c_q` takes the slice carry; `idx` increments.
  - When `idx`==NIBBLES-1, the state moves to DONE, `cout` takes the slice carry, and `ovf` is computed.
- DONE:
  - `done`=1 for exactly one cycle, then the state returns to IDLE unconditionally.
  - `start` in DONE is ignored.
- Overflow: ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]), evaluated with the final MSB nibble.
- `start` is ignored while `busy`=1. Operand changes after acceptance have no effect.
- Intermediate `sum` bits update nibble by nibble during RUN. They are valid only when `done`=1.
- `sum`, `cout` and `ovf` hold their values until the next accepted start.
- On accepted start, `cout` and `ovf` clear to 0. `sum` is not cleared.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0, `idx`=0, `c_q`=0.
- Reset has priority over every other event, including start and mid-RUN.
- Reset aborts the operation with no `done` pulse. Start is accepted on the first edge after reset deasserts.
- Latency, with start accepted at edge E0:
  - `busy`=1 after E0.
  - Nibble k is written at edge E(k+1).
  - `done`=1 in the cycle following edge E(NIBBLES).
  - Return to IDLE at E(NIBBLES+1).
- Throughput: one operation per NIBBLES+2 cycles. WIDTH=16 gives 4 RUN cycles and a 6-cycle issue interval.
- All outputs are registered; there is no combinational path from inputs to outputs.
- The slice is purely combinational between the registered `a_q`/`b_q`/`c_q` and `sum`/`c_q`. The critical path is one 4-bit ripple.

## Configuration
- `RCA_SEQ_SUB_EN` defined:
  - The `sub` port exists and is latched on start.
  - With `sub`=1, `b_q` stores ~b and `c_q` stores 1; `cin` is ignored.
  - `cout`=1 means no borrow. `ovf` uses the stored (inverted) `b_q` MSB.
- `RCA_SEQ_SUB_EN` undefined: no `sub` port; the block performs addition only.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0 -> `sum`=0x5555, `cout`=0, `ovf`=0. `done` is high exactly in the cycle after the 4th edge following acceptance; `busy` is high for 5 cycles.
- a=0xFFFF, b=0x0001, cin=0 -> `sum`=0x0000, `cout`=1, `ovf`=0. a=0x7FFF, b=0x0000, cin=1 -> `sum`=0x8000, `cout`=0, `ovf`=1.
- start pulsed again at RUN idx=2 with a=0x0001, b=0x0001 -> ignored. The first result completes unchanged. A start in the DONE cycle is also ignored, and the next start is accepted only in IDLE.
- reset asserted at idx=2 during a=0xFFFF+0x0001 -> next cycle `busy`=0, `done` never pulses, `sum`=0, `cout`=0. A following 0x0003+0x0004 yields 0x0007.
- Back-to-back: start held high continuously -> operations accepted every 6 cycles. Each `done` pulse is one cycle wide and operands are latched at each acceptance.
- RCA_SEQ_SUB_EN, sub=1, a=0x0005, b=0x0007 -> `sum`=0xFFFE, `cout`=0. a=0x8000, b=0x0001 -> `sum`=0x7FFF, `ovf`=1, `cout`=1.

Source files
------------

// File: rtl/rca_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder reusing one 4-bit ripple slice, LSB nibble first. Optional subtract via `RCA_SEQ_SUB_EN.
// Latency: start accepted at E0, done pulses in the cycle after E(NIBBLES), back in IDLE at E(NIBBLES+1).
// Backpressure: none; start is only sampled in IDLE and is ignored while busy.

// Plain 4-bit ripple-carry slice shared across all nibble steps.
module rcadder_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;

    // Ripple the carry bit by bit through the nibble.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[4];
    end
endmodule

module rca_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef RCA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       slice_a, slice_b, slice_s;
    logic             slice_co;
    logic             op_sub;

`ifdef RCA_SEQ_SUB_EN
    assign op_sub = sub;
`else
    assign op_sub = 1'b0;
`endif

    // The current nibble of the latched operands feeds the shared slice.
    assign slice_a = a_q[4*idx_q +: 4];
    assign slice_b = b_q[4*idx_q +: 4];

    rcadder_4 u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .ci (c_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state: IDLE waits for start, RUN steps NIBBLES times, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (idx_q == LAST_IDX) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then write one slice result per RUN cycle.
    always_comb begin
        idx_d  = idx_q;
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d    = a;
                    // Subtraction is a + ~b + 1; the inverted b is what gets stored.
                    b_d    = op_sub ? ~b : b;
                    c_d    = op_sub ? 1'b1 : cin;
                    idx_d  = '0;
                    cout_d = 1'b0;
                    ovf_d  = 1'b0;
                end
            end
            S_RUN: begin
                sum_d[4*idx_q +: 4] = slice_s;
                c_d                 = slice_co;
                idx_d               = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d  = '0;
                    cout_d = slice_co;
                    // slice_s[3] is the final result MSB, not yet visible in sum_q.
                    ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[3] != a_q[WIDTH-1]);
                end
            end
            default: ;
        endcase
    end

    // Outputs are decodes of registered state only.
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
        sum  = sum_q;
        cout = cout_q;
        ovf  = ovf_q;
    end
endmodule

// File: tb/tb_rca_seq_ctrl.sv
module tb_rca_seq_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a, b;
    logic        cin;
`ifdef RCA_SEQ_SUB_EN
    logic        sub;
`endif
    logic        busy, done, cout, ovf;
    logic [15:0] sum;

    int passed = 0;
    int total  = 0;
    logic [17:0] exp_q[$];
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    rca_seq_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef RCA_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act === exp_v) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    endtask

    // Monitor: every done pulse consumes the oldest expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            check("done_width", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                check("sum",  {16'd0, sum}, {16'd0, e[17:2]});
                check("cout", {31'd0, cout}, {31'd0, e[1]});
                check("ovf",  {31'd0, ovf},  {31'd0, e[0]});
            end
        end
        prev_done = done;
    end

    // Present an operation; caller guarantees the DUT is IDLE at the next edge.
    task automatic accept_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                             input logic [15:0] es, input logic ec, input logic eo);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(posedge clk);
        exp_q.push_back({es, ec, eo});
        #1 start = 1'b0;
    endtask

    // Wait for done (bounded), measuring latency and busy width; return just after the IDLE edge.
    task automatic wait_done(output int lat, output int bcnt);
        bit found = 0;
        lat = 0; bcnt = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (done) found = 1;
        end
        check("done_timeout", {31'd0, found}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                          input logic [15:0] es, input logic ec, input logic eo);
        int lat, bc;
        accept_op(ta, tb_v, tc, es, ec, eo);
        wait_done(lat, bc);
        check("latency", lat, 5);
        check("busy_cycles", bc, 5);
    endtask

    logic [15:0] bb_a [3] = '{16'h0101, 16'hF000, 16'h4000};
    logic [15:0] bb_b [3] = '{16'h0202, 16'h1000, 16'h4000};
    logic [17:0] bb_e [3] = '{{16'h0303, 2'b00}, {16'h0000, 2'b10}, {16'h8000, 2'b01}};

    initial begin
        int lat, bc;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef RCA_SEQ_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum",  {16'd0, sum},  32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_ovf",  {31'd0, ovf},  32'd0);
        reset = 1'b0;

        // Basic additions, carry-out and signed overflow corners.
        run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        @(negedge clk);
        check("sum_hold", {16'd0, sum}, 32'h5555);
        @(posedge clk); #1;
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op(16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0, 1'b0);

        // start mid-RUN and in DONE must be ignored; held start is taken once IDLE.
        accept_op(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; a = 16'h0001; b = 16'h0001;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; a = 16'h0002; b = 16'h0003;
        @(posedge clk);
        @(negedge clk);
        check("done_start_ignored", {31'd0, busy}, 32'd0);
        @(posedge clk);
        exp_q.push_back({16'h0005, 2'b00});
        #1 start = 1'b0;
        wait_done(lat, bc);

        // Reset at idx=2 aborts with no done pulse.
        accept_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum",  {16'd0, sum},  32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
        run_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

        // Back-to-back with start held high: one acceptance every 6 cycles.
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = bb_a[i]; b = bb_b[i]; cin = 1'b0;
            @(posedge clk);
            exp_q.push_back(bb_e[i]);
            #1;
            if (i == 2) start = 1'b0;
            else begin
                // Scramble operands after acceptance; they must not matter.
                a = 16'hDEAD; b = 16'hBEEF;
                repeat (5) @(posedge clk);
                @(negedge clk);
                check("b2b_idle_gap", {31'd0, busy}, 32'd0);
            end
        end
        wait_done(lat, bc);
        check("b2b_latency", lat, 5);

`ifdef RCA_SEQ_SUB_EN
        sub = 1'b1;
        run_op(16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        sub = 1'b0;
`endif

        repeat (4) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
